// File: rtl/alu_ctrl_pkg.sv
// Shared constants for ALU control decode and the multiply/divide sequencer.
package alu_ctrl_pkg;

  typedef logic [3:0] alu_opcode_t;

  localparam alu_opcode_t AluAdd  = 4'b0000;
  localparam alu_opcode_t AluSub  = 4'b0001;
  localparam alu_opcode_t AluAnd  = 4'b0010;
  localparam alu_opcode_t AluXor  = 4'b0011;
  localparam alu_opcode_t AluSll  = 4'b0100;
  localparam alu_opcode_t AluSrl  = 4'b0101;
  localparam alu_opcode_t AluSra  = 4'b0110;
  localparam alu_opcode_t AluSlt  = 4'b0111;
  localparam alu_opcode_t AluLui  = 4'b1000;
  localparam alu_opcode_t AluOr   = 4'b1001;
  localparam alu_opcode_t AluSltu = 4'b1010;

  localparam logic [2:0] AluOpR      = 3'b000;
  localparam logic [2:0] AluOpI      = 3'b001;
  localparam logic [2:0] AluOpLui    = 3'b010;
  localparam logic [2:0] AluOpBranch = 3'b011;
  localparam logic [2:0] AluOpMem    = 3'b100;

  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Sr     = 3'b101;

  localparam logic [2:0] MdMul    = 3'b000;
  localparam logic [2:0] MdMulh   = 3'b001;
  localparam logic [2:0] MdMulhsu = 3'b010;
  localparam logic [2:0] MdMulhu  = 3'b011;
  localparam logic [2:0] MdDiv    = 3'b100;
  localparam logic [2:0] MdDivu   = 3'b101;
  localparam logic [2:0] MdRem    = 3'b110;
  localparam logic [2:0] MdRemu   = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mdu_state_e;

  // funct7=0000000 mapping shared by R-type and I-type
  function automatic alu_opcode_t base_alu_op(input logic [2:0] f3);
    alu_opcode_t op;
    unique case (f3)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_control_mdu_if.sv
// Bus between control unit / instruction fields and ALU control + MDU.
interface alu_control_mdu_if
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic [2:0]      ALU_Op_i;
  logic [2:0]      funct3_i;
  logic [6:0]      funct7_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  alu_opcode_t     ALU_Operation_o;
  logic            mdu_sel_o;
  logic [XLEN-1:0] md_result_o;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic            illegal_o;

  modport master (
    output valid_i, ALU_Op_i, funct3_i, funct7_i, rs1_i, rs2_i,
    input  ALU_Operation_o, mdu_sel_o, md_result_o, stall_o, busy_o, done_o, illegal_o
  );

  modport slave (
    input  valid_i, ALU_Op_i, funct3_i, funct7_i, rs1_i, rs2_i,
    output ALU_Operation_o, mdu_sel_o, md_result_o, stall_o, busy_o, done_o, illegal_o
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply (shift-add) / restoring divide on magnitudes with sign fix-up.
module mdu_iter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            early_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o
);
  logic [2:0]        op_q;
  logic              neg_a_q, neg_b_q, div_zero_q;
  logic [XLEN-1:0]   mcand_q, hi_q, lo_q, result_q;
  logic              a_signed, b_signed, neg_a, neg_b, is_div;
  logic [XLEN-1:0]   mag_a, mag_b, early_result;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_fits;
  logic [XLEN-1:0]   hi_d, lo_d, quo_s, rem_s, fixed;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    a_signed     = op_i inside {MdMulh, MdMulhsu, MdDiv, MdRem};
    b_signed     = op_i inside {MdMulh, MdDiv, MdRem};
    neg_a        = a_signed & rs1_i[XLEN-1];
    neg_b        = b_signed & rs2_i[XLEN-1];
    mag_a        = neg_a ? -rs1_i : rs1_i;
    mag_b        = neg_b ? -rs2_i : rs2_i;
    early_result = op_i[2] ? (op_i[1] ? rs1_i : '1) : '0;
  end

  // {hi,lo} is the product accumulator for multiply, {remainder,quotient} for divide
  always_comb begin
    is_div    = op_q[2];
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_fits  = ~div_diff[XLEN];
    if (is_div) begin
      hi_d = div_fits ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_fits};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod   = {hi_d, lo_d};
    prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quo_s  = div_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_d : lo_d);
    rem_s  = neg_a_q ? -hi_d : hi_d;
    fixed  = rem_s;
    case (op_q)
      MdMul:                    fixed = prod_s[XLEN-1:0];
      MdMulh, MdMulhsu, MdMulhu: fixed = prod_s[2*XLEN-1:XLEN];
      MdDiv, MdDivu:            fixed = quo_s;
      MdRem, MdRemu:            fixed = rem_s;
      default:                  fixed = rem_s;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
    end else begin
      if (start_i) begin
        op_q       <= op_i;
        neg_a_q    <= neg_a;
        neg_b_q    <= neg_b;
        div_zero_q <= op_i[2] && (rs2_i == '0);
        mcand_q    <= mag_b;
        hi_q       <= '0;
        lo_q       <= mag_a;
      end else if (step_i) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
      if (early_i) begin
        result_q <= early_result;
      end else if (step_i && last_i) begin
        result_q <= fixed;
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus RV32M multiply/divide sequencer.
// Define ALU_CTRL_EARLY_DONE_EN to finish trivial M-ops (zero operand / divide by zero) in 1 cycle.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input logic              clk,
  input logic              reset,
  alu_control_mdu_if.slave bus
);
  mdu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_opcode_t alu_op;
  logic        illegal, m_op, accept, early;

  always_comb begin
    alu_op  = AluAdd;
    illegal = 1'b0;
    case (bus.ALU_Op_i)
      AluOpR: begin
        if (bus.funct7_i == F7Zero) begin
          alu_op = base_alu_op(bus.funct3_i);
        end else if (bus.funct7_i == F7Alt && bus.funct3_i == F3AddSub) begin
          alu_op = AluSub;
        end else if (bus.funct7_i == F7Alt && bus.funct3_i == F3Sr) begin
          alu_op = AluSra;
        end else if (bus.funct7_i != F7MulDiv) begin
          illegal = 1'b1;
        end
      end
      AluOpI: begin
        if (bus.funct3_i == F3Sll) begin
          if (bus.funct7_i == F7Zero) alu_op = AluSll;
          else                        illegal = 1'b1;
        end else if (bus.funct3_i == F3Sr) begin
          if      (bus.funct7_i == F7Zero) alu_op = AluSrl;
          else if (bus.funct7_i == F7Alt)  alu_op = AluSra;
          else                             illegal = 1'b1;
        end else begin
          alu_op = base_alu_op(bus.funct3_i);
        end
      end
      AluOpLui:    alu_op = AluLui;
      AluOpBranch: alu_op = AluSub;
      AluOpMem:    alu_op = AluAdd;
      default:     illegal = 1'b1;
    endcase
    if (illegal) alu_op = AluAdd;
  end

  assign m_op   = (bus.ALU_Op_i == AluOpR) && (bus.funct7_i == F7MulDiv);
  assign accept = (state_q == StIdle) && bus.valid_i && m_op;

`ifdef ALU_CTRL_EARLY_DONE_EN
  assign early = accept && (bus.funct3_i[2] ? (bus.rs2_i == '0)
                                            : (bus.rs1_i == '0 || bus.rs2_i == '0));
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = CNT_W'(XLEN - 1);
          state_d = early ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept),
    .early_i (early),
    .step_i  (state_q == StBusy),
    .last_i  (cnt_q == '0),
    .op_i    (bus.funct3_i),
    .rs1_i   (bus.rs1_i),
    .rs2_i   (bus.rs2_i),
    .result_o(bus.md_result_o)
  );

  assign bus.ALU_Operation_o = alu_op;
  assign bus.illegal_o       = illegal;
  assign bus.mdu_sel_o       = m_op;
  assign bus.stall_o         = accept || (state_q == StBusy);
  assign bus.busy_o          = state_q != StIdle;
  assign bus.done_o          = state_q == StDone;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench: directed decode/MDU corners plus random M-ops against a reference model.
module tb_alu_control_mdu;
  localparam int unsigned XLEN = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  alu_control_mdu_if #(.XLEN(XLEN)) bus ();

  alu_control_mdu #(.XLEN(XLEN)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference M-op results from plain 64-bit / signed arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (f3)
      3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = 32'($signed(a) / $signed(b));
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else r = 32'($signed(a) % $signed(b));
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Returns {illegal, mdu_sel, alu_op[3:0]}
  function automatic logic [5:0] ref_dec(input logic [2:0] aop, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [31:0] tbl;
    logic [3:0]  op;
    logic        ill, sel;
    // funct3 7..0 -> AND OR SRL XOR SLTU SLT SLL ADD
    tbl = {4'b0010, 4'b1001, 4'b0101, 4'b0011, 4'b1010, 4'b0111, 4'b0100, 4'b0000};
    op = 4'b0000; ill = 1'b0; sel = 1'b0;
    if (aop == 3'd0) begin
      if (f7 == 7'h01) sel = 1'b1;
      else if (f7 == 7'h00) op = tbl[f3*4 +: 4];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 4'b0001;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 4'b0110;
      else ill = 1'b1;
    end else if (aop == 3'd1) begin
      if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
      else if (f3 == 3'd5 && f7 == 7'h20) op = 4'b0110;
      else if (f3 == 3'd5 && f7 != 7'h00) ill = 1'b1;
      else op = tbl[f3*4 +: 4];
    end else if (aop == 3'd2) op = 4'b1000;
    else if (aop == 3'd3) op = 4'b0001;
    else if (aop == 3'd4) op = 4'b0000;
    else ill = 1'b1;
    if (ill) op = 4'b0000;
    return {ill, sel, op};
  endfunction

  task automatic check_dec(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7);
    logic [5:0] exp;
    string      tag;
    bus.ALU_Op_i = aop;
    bus.funct3_i = f3;
    bus.funct7_i = f7;
    #1;
    exp = ref_dec(aop, f3, f7);
    tag = $sformatf("dec aop=%0d f3=%0d f7=%h", aop, f3, f7);
    check({tag, " alu_op"}, {28'b0, bus.ALU_Operation_o}, {28'b0, exp[3:0]});
    check({tag, " illegal"}, {31'b0, bus.illegal_o}, {31'b0, exp[5]});
    check({tag, " mdu_sel"}, {31'b0, bus.mdu_sel_o}, {31'b0, exp[4]});
  endtask

  task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input string tag, output logic [31:0] got);
    logic [31:0] exp;
    int          exp_stall, stall_cnt, waited;
    logic        early;
    exp   = ref_md(f3, a, b);
    early = 1'b0;
`ifdef ALU_CTRL_EARLY_DONE_EN
    early = f3[2] ? (b == 0) : (a == 0 || b == 0);
`endif
    exp_stall = early ? 1 : XLEN + 1;
    @(negedge clk);
    bus.valid_i  = 1'b1;
    bus.ALU_Op_i = 3'd0;
    bus.funct7_i = 7'h01;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    #1;
    check({tag, " alu_op"}, {28'b0, bus.ALU_Operation_o}, 32'h0);
    stall_cnt = 0;
    waited    = 0;
    while (bus.done_o !== 1'b1 && waited < 3 * XLEN) begin
      if (bus.stall_o === 1'b1) stall_cnt++;
      @(posedge clk);
      #1;
      // Operands are scrambled while busy; the result must not depend on them
      bus.valid_i = 1'b0;
      bus.rs1_i   = $urandom();
      bus.rs2_i   = $urandom();
      waited++;
    end
    got = bus.md_result_o;
    check({tag, " done"}, {31'b0, bus.done_o}, 32'd1);
    check({tag, " stall cycles"}, stall_cnt, exp_stall);
    check({tag, " stall in done"}, {31'b0, bus.stall_o}, 32'd0);
    check({tag, " result"}, got, exp);
    // Offer an M-op during DONE: it must not be taken
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " busy after done"}, {31'b0, bus.busy_o}, 32'd0);
    check({tag, " done pulse width"}, {31'b0, bus.done_o}, 32'd0);
    bus.valid_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 20));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] got;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a, b;

    bus.valid_i  = 1'b0;
    bus.ALU_Op_i = 3'd0;
    bus.funct3_i = 3'd0;
    bus.funct7_i = 7'd0;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;

    // Reset state, and decode stays live while reset is held
    #3;
    check("reset busy", {31'b0, bus.busy_o}, 32'd0);
    check("reset done", {31'b0, bus.done_o}, 32'd0);
    check("reset result", bus.md_result_o, 32'd0);
    check("reset stall", {31'b0, bus.stall_o}, 32'd0);
    bus.ALU_Op_i = 3'd2;
    #1;
    check("decode in reset", {28'b0, bus.ALU_Operation_o}, 32'h8);
    @(negedge clk);
    reset = 1'b1;

    // Directed decode points
    bus.ALU_Op_i = 3'd0; bus.funct3_i = 3'd5; bus.funct7_i = 7'h20; #1;
    check("dec R sra", {28'b0, bus.ALU_Operation_o}, 32'h6);
    bus.ALU_Op_i = 3'd1; bus.funct3_i = 3'd0; bus.funct7_i = 7'h20; #1;
    check("dec I add f7alt", {28'b0, bus.ALU_Operation_o}, 32'h0);
    bus.ALU_Op_i = 3'd2; #1;
    check("dec lui", {28'b0, bus.ALU_Operation_o}, 32'h8);
    bus.ALU_Op_i = 3'd0; bus.funct3_i = 3'd1; bus.funct7_i = 7'h20; #1;
    check("dec R sll alt illegal", {31'b0, bus.illegal_o}, 32'd1);
    check("dec illegal gives add", {28'b0, bus.ALU_Operation_o}, 32'h0);

    // Random decode sweep against the rule model
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom());
      endcase
      check_dec(3'($urandom_range(0, 7)), 3'($urandom()), f7);
    end

    // Directed M-ops
    run_mop(3'd0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3", got);
    check("mul 7*-3 const", got, 32'hFFFF_FFEB);
    run_mop(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh", got);
    check("mulh const", got, 32'h4000_0000);
    run_mop(3'd3, 32'h8000_0000, 32'h8000_0000, "mulhu", got);
    check("mulhu const", got, 32'h4000_0000);
    run_mop(3'd2, 32'h8000_0000, 32'h8000_0000, "mulhsu", got);
    check("mulhsu const", got, 32'hC000_0000);
    run_mop(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", got);
    check("div ovf const", got, 32'h8000_0000);
    run_mop(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf", got);
    check("rem ovf const", got, 32'h0);
    run_mop(3'd5, 32'd5, 32'd0, "divu by0", got);
    check("divu by0 const", got, 32'hFFFF_FFFF);
    run_mop(3'd7, 32'd5, 32'd0, "remu by0", got);
    check("remu by0 const", got, 32'd5);
    run_mop(3'd4, 32'hFFFF_FFF9, 32'd2, "div -7/2", got);
    check("div -7/2 const", got, 32'hFFFF_FFFD);
    run_mop(3'd6, 32'hFFFF_FFF9, 32'd2, "rem -7/2", got);
    check("rem -7/2 const", got, 32'hFFFF_FFFF);
    run_mop(3'd4, 32'hFFFF_FFF9, 32'd0, "div -7/0", got);
    run_mop(3'd6, 32'hFFFF_FFF9, 32'd0, "rem -7/0", got);
    run_mop(3'd0, 32'd0, 32'd1234, "mul zero", got);
    check("mul zero const", got, 32'd0);

    // Random M-ops
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom());
      a  = pick_operand();
      b  = pick_operand();
      run_mop(f3, a, b, $sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b), got);
    end

    // Reset in the middle of a divide
    run_mop(3'd5, 32'd77, 32'd3, "pre-reset divu", got);
    @(negedge clk);
    bus.valid_i = 1'b1; bus.ALU_Op_i = 3'd0; bus.funct7_i = 7'h01;
    bus.funct3_i = 3'd4; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd9;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    check("busy before reset", {31'b0, bus.busy_o}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid reset busy", {31'b0, bus.busy_o}, 32'd0);
    check("mid reset done", {31'b0, bus.done_o}, 32'd0);
    check("mid reset result", bus.md_result_o, 32'd0);
    check("mid reset stall", {31'b0, bus.stall_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_mop(3'd5, 32'd100, 32'd7, "post-reset divu", got);
    check("post-reset divu const", got, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Next-generation ALU control for the RISC-V core. Decodes ALU_Op/funct3/funct7 into a 4-bit ALU operation code for all RV32I ALU operations.
- Adds a sequencer for RV32M multiply/divide with a parametrised iterative multiplier and divider.
- Sits between the control unit, the instruction bus and the ALU/result mux.
- Stalls the PC while a multi-cycle operation runs.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- valid_i  input  1  instruction on the bus is valid this cycle
- ALU_Op_i  input  3  from control unit: 000 R-type, 001 I-type ALU, 010 LUI, 011 branch-compare, 100 load/store address
- funct3_i  input  3  instruction[14:12]
- funct7_i  input  7  instruction[31:25]
- rs1_i  input  XLEN  operand A
- rs2_i  input  XLEN  operand B
- ALU_Operation_o  output  4  ALU operation code; combinational
- mdu_sel_o  output  1  result mux selects md_result_o; combinational
- md_result_o  output  XLEN  multiply/divide result; valid while done_o=1
- stall_o  output  1  hold PC and register-file write
- busy_o  output  1  sequencer not IDLE
- done_o  output  1  one-cycle completion pulse
- illegal_o  output  1  unsupported encoding; combinational

Behaviour:
- ALU operation codes (package constants): ADD 0000, SUB 0001, AND 0010, XOR 0011, SLL 0100, SRL 0101, SRA 0110, SLT 0111, LUI 1000, OR 1001, SLTU 1010.
- Decode for R-type, funct7 0000000: funct3 000/001/010/011/100/101/110/111 map to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
- Decode for R-type, funct7 0100000: funct3 000 gives SUB; funct3 101 gives SRA.
- Decode for I-type: same as R-type except funct3 000 is always ADD. SLLI requires funct7=0000000. SRLI/SRAI use funct7 0000000/0100000.
- Decode for other ALU_Op values: LUI gives LUI; branch gives SUB; load/store gives ADD.
- Any other encoding: illegal_o=1 and ALU_Operation_o=ADD.
- M-op is defined as ALU_Op=000 and funct7=0000001. For an M-op: mdu_sel_o=1 and ALU_Operation_o=ADD.
- M-op funct3 mapping: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- State machine IDLE, BUSY, DONE.
  - IDLE: if valid_i=1 and M-op, capture operands, op and sign info at the edge; counter=XLEN-1; go to BUSY.
  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide, on magnitudes). At counter=0, apply sign correction and go to DONE. Otherwise decrement the counter.
  - DONE: done_o=1 and md_result_o valid; unconditionally return to IDLE. An M-op seen in DONE is not re-accepted.
- stall_o = (IDLE and valid_i and M-op) or BUSY. It is low in DONE, so the PC advances at the end of DONE.
- Latency: acceptance at edge k; done_o=1 in the cycle following edge k+XLEN.
- Inputs other than clk/reset are ignored in BUSY and DONE.
- MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN signed×signed, signed×unsigned and unsigned×unsigned products.
- Divide by zero: quotient all ones; remainder = rs1.
- Signed overflow (most-negative / -1): quotient = rs1; remainder = 0.
- Reset, asynchronous at any time: state IDLE; counter, md_result_o, done_o, busy_o and internal registers 0. An in-flight operation is discarded.
- Combinational outputs follow their inputs regardless of reset state.

Optional Feature:
- ALU_CTRL_EARLY_DONE_EN defined: in IDLE an accepted M-op goes straight to DONE (latency 1) for either of these cases:
  - rs2=0 (div/rem), with the defined divide-by-zero result;
  - either multiply operand is 0, with result 0.
- ALU_CTRL_EARLY_DONE_EN undefined: every M-op takes the full XLEN+1 latency; results are identical.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU operation code constants;
  - ALU_Op encodings;
  - funct7 constants (0000000, 0100000, 0000001);
  - M-op funct3 constants;
  - state encoding.
- One sub-module, mdu_iter: holds the datapath registers, the shift-add/restoring step and the sign fix-up.
- alu_control_mdu keeps the decode logic and the FSM.

Test Plan:
- Decode sweep: R-type funct7=0100000, funct3=101 -> ALU_Operation_o=0110; I-type funct3=000, funct7=0100000 -> 0000; ALU_Op=010 -> 1000; R-type funct7=0100000, funct3=001 -> illegal_o=1.
- MUL, XLEN=32: rs1=7, rs2=-3 (0xFFFFFFFD) -> stall_o high for 33 cycles; done_o pulses in cycle 34 after acceptance with md_result_o=0xFFFFFFEB; stall_o low in the done cycle.
- MULH/MULHU: rs1=rs2=0x80000000 -> MULH gives 0x40000000; MULHU gives 0x40000000; MULHSU gives 0xC0000000.
- DIV/REM corners: 0x80000000 / 0xFFFFFFFF -> DIV 0x80000000, REM 0; 5 / 0 -> DIVU 0xFFFFFFFF, REMU 5; -7 / 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
- Reset mid-op: reset low at BUSY count 10 -> busy_o=0, done_o=0, md_result_o=0 immediately. After release, a new DIVU 100/7 gives 14 with full latency.
- Early done, macro defined: MUL with rs1=0 -> done_o one cycle after acceptance, result 0. Macro undefined: same stimulus -> 33-cycle stall.
